instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the DRFA CPU: owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ready handshake, and holds the fetched word in the instruction register that drives the microcoded control unit's `in_ir`. The control unit's `out_pc_load`, `out_pc_inc` and `out_ir_enable_read` outputs drive this block directly. The control unit's `out_decode` must not be issued until `out_ir_valid` is high.

## Interface
- `PC_WIDTH`, 8: program counter and instruction address width (words).
- `IR_WIDTH`, 16: instruction word width. Opcode is `[IR_WIDTH-1:IR_WIDTH-5]`.

Ports:
- `clk` in 1: the only clock. All state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_pc_load` in 1: load PC from `in_pc_value`.
- `in_pc_value` in PC_WIDTH: jump target.
- `in_pc_inc` in 1: PC <= PC + 1.
- `in_ir_enable_read` in 1: start a fetch at the current PC.
- `out_imem_addr` out PC_WIDTH: instruction memory address.
- `out_imem_req` out 1: memory request, level.
- `in_imem_data` in IR_WIDTH: memory read data, valid with `in_imem_ready`.
- `in_imem_ready` in 1: completes the request in the cycle it is sampled high.
- `out_ir` out IR_WIDTH: instruction register.
- `out_ir_valid` out 1: `out_ir` holds the word fetched by the most recent fetch.
- `out_pc` out PC_WIDTH: current PC.
- `out_busy` out 1: a fetch is in progress (state != IDLE).

## Operation
- States: IDLE, REQ, DONE.
- IDLE -> REQ: when `in_ir_enable_read`=1.
  - The fetch address register captures `out_pc`.
  - `out_ir_valid` clears.
- REQ:
  - `out_imem_req`=1 and `out_imem_addr` = the captured address. Both stay stable until ready.
  - On `in_imem_ready`=1: `out_ir` <= `in_imem_data`, go to DONE.
- DONE -> IDLE: unconditional. `out_ir_valid` sets on entry to DONE.
- `in_ir_enable_read` is ignored in REQ and DONE; it is not queued.
- PC update is independent of the FSM and legal in any state.
  - Load has priority over inc.
  - Increment wraps modulo 2^PC_WIDTH (all-ones + 1 = 0).
  - PC changes during REQ do not alter the in-flight address.
- `out_ir` holds its value until the next completed fetch.

## Timing
- Reset values: PC=0, `out_ir`=0, `out_ir_valid`=0, `out_imem_req`=0, `out_imem_addr`=0, `out_busy`=0, state IDLE.
- Reset mid-fetch: request drops on that edge; a coincident `in_imem_ready` is ignored.
- Fetch latency, from `in_ir_enable_read` sampled at edge N with ready returned in the first request cycle:
  - `out_imem_req` high after edge N.
  - `out_ir` / `out_ir_valid` updated after edge N+1.
  - Back in IDLE after edge N+2.
- Each wait cycle adds 1.
- `out_imem_req` is registered; no combinational path from `in_imem_ready` to any output.
- In the same edge, `in_pc_inc` and `in_ir_enable_read` together: the fetch uses the pre-increment PC.

## Configuration
- `FETCH_PREFETCH_EN` defined: one-entry prefetch buffer (data, address, valid).
  - On entering DONE, the block automatically requests captured address + 1 (wrapping) while otherwise idle, and stores the result in the buffer.
  - A fetch whose PC equals the buffered address with buffer valid skips REQ: IDLE -> DONE, latency 1 edge, no memory request.
  - `in_pc_load` invalidates the buffer and aborts any in-flight prefetch. The abort takes effect after the current handshake completes; the returned data is discarded.
  - Demand fetch arriving during a prefetch waits for it, then hits or misses.
  - `out_busy` does not reflect the background prefetch.
- Undefined: no buffer; every fetch goes through REQ.

## Structure
- Shared package `drfa_pkg`:
  - FSM state enum.
  - `PC_WIDTH` and `IR_WIDTH` defaults.
  - Opcode field position constants, shared with the control unit's decode.
- Sub-module `fetch_prefetch_buf`: buffer storage plus address compare. Instantiated only under `FETCH_PREFETCH_EN`.

## Test plan
- Reset, then enable read with memory `0x2A55` at address 0, ready immediate -> `out_ir`=0x2A55 and valid after 2 edges; `out_imem_addr`=0; PC stays 0.
- Ready delayed 3 cycles -> req and address stable throughout; valid only after ready; enable pulses during REQ ignored.
- PC=0xFF with `in_pc_inc` -> PC=0x00. Load 0x40 and inc together -> PC=0x40.
- Load 0x10 during REQ for address 5 -> `out_ir` = mem[5]; next fetch addresses 0x10.
- `rst_n` low during REQ with ready high -> req=0, `out_ir`=0, valid=0 next cycle.
- `FETCH_PREFETCH_EN`:
  - Fetch 3, inc, fetch 4 -> second fetch completes in 1 edge with no req.
  - Fetch 3, load 9, fetch 9 -> full handshake, `out_ir` = mem[9].

Source files
------------

// File: rtl/drfa_pkg.sv
// Shared DRFA CPU definitions: fetch FSM encoding, datapath width defaults, opcode field position.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package drfa_pkg;

    localparam int PC_WIDTH_DEF = 8;
    localparam int IR_WIDTH_DEF = 16;

    // Opcode occupies the top five bits of the instruction word; decode uses the same slice.
    localparam int OPCODE_W   = 5;
    localparam int OPCODE_MSB = IR_WIDTH_DEF - 1;
    localparam int OPCODE_LSB = IR_WIDTH_DEF - OPCODE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [IR_WIDTH_DEF-1:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer: holds one instruction word with its address and answers hit lookups.
// Latency: fill visible one edge after fill_vld_i; lookup is combinational on stored state.
// Backpressure: none, always accepts a fill; invalidate wins over a coincident fill.
import drfa_pkg::*;

module fetch_prefetch_buf #(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inv_i,
    input  logic                fill_vld_i,
    input  logic [PC_WIDTH-1:0] fill_addr_i,
    input  logic [IR_WIDTH-1:0] fill_dat_i,
    input  logic [PC_WIDTH-1:0] lookup_addr_i,
    output logic                hit_o,
    output logic [IR_WIDTH-1:0] dat_o
);

    logic                vld_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [IR_WIDTH-1:0] dat_q;

    // Entry storage: a PC load makes the buffered word stale, so invalidate first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
        end else if (inv_i) begin
            vld_q  <= 1'b0;
        end else if (fill_vld_i) begin
            vld_q  <= 1'b1;
            addr_q <= fill_addr_i;
            dat_q  <= fill_dat_i;
        end
    end

    assign hit_o = vld_q && (addr_q == lookup_addr_i);
    assign dat_o = dat_q;

endmodule

// File: rtl/instruction_fetch.sv
// DRFA fetch stage: owns the PC, fetches one word per enable into the IR; optional FETCH_PREFETCH_EN adds a next-word buffer.
// Latency: enable to IR valid is 2 edges with immediate ready (+1 per wait cycle); 1 edge on a prefetch hit.
// Backpressure: request held stable until in_imem_ready; enables arriving while busy are dropped, not queued.
import drfa_pkg::*;

module instruction_fetch #(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_pc_load,
    input  logic [PC_WIDTH-1:0] in_pc_value,
    input  logic                in_pc_inc,
    input  logic                in_ir_enable_read,
    output logic [PC_WIDTH-1:0] out_imem_addr,
    output logic                out_imem_req,
    input  logic [IR_WIDTH-1:0] in_imem_data,
    input  logic                in_imem_ready,
    output logic [IR_WIDTH-1:0] out_ir,
    output logic                out_ir_valid,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_busy
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                ir_vld_q, ir_vld_d;
    logic                req_q, req_d;

`ifdef FETCH_PREFETCH_EN
    // Demand address is kept apart from mem_addr because the memory port may be busy with a prefetch.
    logic [PC_WIDTH-1:0] dmd_addr_q, dmd_addr_d;
    logic                pf_q, pf_d;
    logic                pf_abort_q, pf_abort_d;
    logic                buf_fill;
    logic                buf_hit;
    logic [IR_WIDTH-1:0] buf_dat;
    logic [PC_WIDTH-1:0] buf_lookup;

    assign buf_lookup = (state_q == ST_IDLE) ? pc_q : dmd_addr_q;

    fetch_prefetch_buf #(
        .PC_WIDTH (PC_WIDTH),
        .IR_WIDTH (IR_WIDTH)
    ) u_pf_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .inv_i         (in_pc_load),
        .fill_vld_i    (buf_fill),
        .fill_addr_i   (mem_addr_q),
        .fill_dat_i    (in_imem_data),
        .lookup_addr_i (buf_lookup),
        .hit_o         (buf_hit),
        .dat_o         (buf_dat)
    );
`endif

    // PC next value: load beats increment, increment wraps naturally at the register width.
    always_comb begin
        pc_d = pc_q;
        if (in_pc_load) begin
            pc_d = in_pc_value;
        end else if (in_pc_inc) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // Fetch FSM next state, memory request and IR update.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_vld_d   = ir_vld_q;
        req_d      = req_q;
`ifdef FETCH_PREFETCH_EN
        dmd_addr_d = dmd_addr_q;
        pf_d       = pf_q;
        pf_abort_d = pf_abort_q | (pf_q & in_pc_load);
        buf_fill   = 1'b0;
        // Background prefetch completes independently of the FSM; aborted data is dropped.
        if (pf_q && req_q && in_imem_ready) begin
            req_d      = 1'b0;
            pf_d       = 1'b0;
            pf_abort_d = 1'b0;
            buf_fill   = !pf_abort_q && !in_pc_load;
        end
        case (state_q)
            ST_IDLE: begin
                if (in_ir_enable_read) begin
                    dmd_addr_d = pc_q;
                    ir_vld_d   = 1'b0;
                    state_d    = ST_REQ;
                    if (!pf_q && buf_hit) begin
                        ir_d     = buf_dat;
                        ir_vld_d = 1'b1;
                        state_d  = ST_DONE;
                    end else if (!pf_q) begin
                        req_d      = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
            end
            ST_REQ: begin
                // With no request outstanding the port was busy with a prefetch: retry lookup, else issue.
                if (!req_q) begin
                    if (buf_hit) begin
                        ir_d     = buf_dat;
                        ir_vld_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        req_d      = 1'b1;
                        mem_addr_d = dmd_addr_q;
                    end
                end else if (!pf_q && in_imem_ready) begin
                    ir_d     = in_imem_data;
                    ir_vld_d = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Entering DONE the memory port is free: start fetching the next sequential word.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            req_d      = 1'b1;
            pf_d       = 1'b1;
            mem_addr_d = dmd_addr_d + PC_ONE;
            pf_abort_d = in_pc_load;
        end
`else
        case (state_q)
            ST_IDLE: begin
                if (in_ir_enable_read) begin
                    mem_addr_d = pc_q;
                    ir_vld_d   = 1'b0;
                    req_d      = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (in_imem_ready) begin
                    ir_d     = in_imem_data;
                    ir_vld_d = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    // State registers; reset drops any in-flight request and ignores a coincident ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            mem_addr_q <= '0;
            ir_q       <= '0;
            ir_vld_q   <= 1'b0;
            req_q      <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            dmd_addr_q <= '0;
            pf_q       <= 1'b0;
            pf_abort_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_vld_q   <= ir_vld_d;
            req_q      <= req_d;
`ifdef FETCH_PREFETCH_EN
            dmd_addr_q <= dmd_addr_d;
            pf_q       <= pf_d;
            pf_abort_q <= pf_abort_d;
`endif
        end
    end

    assign out_imem_addr = mem_addr_q;
    assign out_imem_req  = req_q;
    assign out_ir        = ir_q;
    assign out_ir_valid  = ir_vld_q;
    assign out_pc        = pc_q;
    assign out_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small memory responder of configurable wait cycles.
// Latency: checks sampled on the falling edge, one half cycle after the edge under test.
// Backpressure: responder holds ready low for resp_delay cycles of each request.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_pc_load;
    logic [7:0]  in_pc_value;
    logic        in_pc_inc;
    logic        in_ir_enable_read;
    logic [7:0]  out_imem_addr;
    logic        out_imem_req;
    logic [15:0] in_imem_data;
    logic        in_imem_ready;
    logic [15:0] out_ir;
    logic        out_ir_valid;
    logic [7:0]  out_pc;
    logic        out_busy;

    int n_chk = 0;
    int n_bad = 0;
    int resp_delay = 0;
    logic ready_force = 1'b0;
    logic req_seen;
    int wait_cnt;

    instruction_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_pc_load        (in_pc_load),
        .in_pc_value       (in_pc_value),
        .in_pc_inc         (in_pc_inc),
        .in_ir_enable_read (in_ir_enable_read),
        .out_imem_addr     (out_imem_addr),
        .out_imem_req      (out_imem_req),
        .in_imem_data      (in_imem_data),
        .in_imem_ready     (in_imem_ready),
        .out_ir            (out_ir),
        .out_ir_valid      (out_ir_valid),
        .out_pc            (out_pc),
        .out_busy          (out_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: address 0 holds 0x2A55, others {addr, addr^0xC3}.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (a == 8'h00) return 16'h2A55;
        return {a, a ^ 8'hC3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: ready after resp_delay cycles of a held request.
    initial begin
        in_imem_ready = 1'b0;
        in_imem_data  = 16'h0;
        req_seen      = 1'b0;
        wait_cnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (req_seen && !in_imem_ready) wait_cnt++;
            else wait_cnt = 0;
            req_seen      = out_imem_req;
            in_imem_ready = ready_force || (out_imem_req && (wait_cnt >= resp_delay));
            in_imem_data  = mem_word(out_imem_addr);
        end
    end

    initial begin
        rst_n             = 1'b0;
        in_pc_load        = 1'b0;
        in_pc_value       = 8'h00;
        in_pc_inc         = 1'b0;
        in_ir_enable_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc",   out_pc, 0);
        chk("rst_ir",   out_ir, 0);
        chk("rst_vld",  out_ir_valid, 0);
        chk("rst_req",  out_imem_req, 0);
        chk("rst_addr", out_imem_addr, 0);
        chk("rst_busy", out_busy, 0);
        rst_n = 1'b1;

`ifdef FETCH_PREFETCH_EN
        // Fetch 3 through memory; prefetch of 4 follows automatically.
        in_pc_load = 1'b1; in_pc_value = 8'h03;
        @(negedge clk);
        in_pc_load = 1'b0; in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        chk("p1_req",  out_imem_req, 1);
        chk("p1_addr", out_imem_addr, 8'h03);
        @(negedge clk);
        chk("p1_ir",      out_ir, 16'h03C0);
        chk("p1_vld",     out_ir_valid, 1);
        chk("p1_pf_req",  out_imem_req, 1);
        chk("p1_pf_addr", out_imem_addr, 8'h04);
        @(negedge clk);
        chk("p1_idle",    out_busy, 0);
        chk("p1_pf_done", out_imem_req, 0);
        // inc to 4, fetch 4: buffer hit, one edge, no demand request.
        in_pc_inc = 1'b1;
        @(negedge clk);
        in_pc_inc = 1'b0;
        chk("p2_pc",  out_pc, 8'h04);
        chk("p2_req", out_imem_req, 0);
        in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        chk("p2_vld",  out_ir_valid, 1);
        chk("p2_ir",   out_ir, 16'h04C7);
        chk("p2_busy", out_busy, 1);
        chk("p2_addr", out_imem_addr, 8'h05);
        @(negedge clk);
        // Fetch 3 again, then load 9 while prefetch of 4 is in flight, fetch 9.
        in_pc_load = 1'b1; in_pc_value = 8'h03;
        @(negedge clk);
        in_pc_load = 1'b0; in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        chk("p3_req",  out_imem_req, 1);
        chk("p3_addr", out_imem_addr, 8'h03);
        @(negedge clk);
        chk("p3_ir", out_ir, 16'h03C0);
        in_pc_load = 1'b1; in_pc_value = 8'h09;
        @(negedge clk);
        in_pc_load = 1'b0;
        chk("p3_pc",      out_pc, 8'h09);
        chk("p3_req_low", out_imem_req, 0);
        in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        chk("p3_miss_req",  out_imem_req, 1);
        chk("p3_miss_addr", out_imem_addr, 8'h09);
        @(negedge clk);
        chk("p3_ir9",  out_ir, 16'h09CA);
        chk("p3_vld9", out_ir_valid, 1);
`else
        // Fetch address 0, ready immediately.
        in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        chk("t1_req",     out_imem_req, 1);
        chk("t1_addr",    out_imem_addr, 0);
        chk("t1_busy",    out_busy, 1);
        chk("t1_vld_clr", out_ir_valid, 0);
        @(negedge clk);
        chk("t1_ir",       out_ir, 16'h2A55);
        chk("t1_vld",      out_ir_valid, 1);
        chk("t1_pc",       out_pc, 0);
        chk("t1_req_drop", out_imem_req, 0);
        @(negedge clk);
        chk("t1_idle", out_busy, 0);

        // Fetch 5 with 3 wait cycles; load 0x10 and an enable pulse during REQ.
        in_pc_load = 1'b1; in_pc_value = 8'h05;
        @(negedge clk);
        in_pc_load = 1'b0;
        resp_delay = 3;
        in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_req",  out_imem_req, 1);
            chk("t2_addr", out_imem_addr, 8'h05);
            chk("t2_vld",  out_ir_valid, 0);
            in_pc_load        = (i == 0);
            in_pc_value       = 8'h10;
            in_ir_enable_read = (i == 1);
            @(negedge clk);
        end
        in_pc_load = 1'b0; in_ir_enable_read = 1'b0;
        chk("t2_ir",   out_ir, 16'h05C6);
        chk("t2_vld1", out_ir_valid, 1);
        chk("t2_pc",   out_pc, 8'h10);
        chk("t2_done", out_busy, 1);
        @(negedge clk);
        chk("t2_no_queue", out_busy, 0);
        resp_delay = 0;
        in_ir_enable_read = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0;
        chk("t2_next_addr", out_imem_addr, 8'h10);
        @(negedge clk);
        chk("t2_next_ir", out_ir, 16'h10D3);
        @(negedge clk);

        // PC wrap and load-over-inc priority.
        in_pc_load = 1'b1; in_pc_value = 8'hFF;
        @(negedge clk);
        in_pc_load = 1'b0;
        chk("t3_pc_ff", out_pc, 8'hFF);
        in_pc_inc = 1'b1;
        @(negedge clk);
        chk("t3_wrap", out_pc, 8'h00);
        in_pc_load = 1'b1; in_pc_value = 8'h40;
        @(negedge clk);
        in_pc_load = 1'b0; in_pc_inc = 1'b0;
        chk("t3_prio", out_pc, 8'h40);

        // Inc with enable uses old PC; then reset mid-fetch with ready high.
        in_pc_load = 1'b1; in_pc_value = 8'h07;
        @(negedge clk);
        in_pc_load = 1'b0;
        resp_delay = 10;
        in_ir_enable_read = 1'b1; in_pc_inc = 1'b1;
        @(negedge clk);
        in_ir_enable_read = 1'b0; in_pc_inc = 1'b0;
        chk("t4_addr", out_imem_addr, 8'h07);
        chk("t4_pc",   out_pc, 8'h08);
        chk("t4_req",  out_imem_req, 1);
        ready_force = 1'b1; in_imem_ready = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_req",  out_imem_req, 0);
        chk("t4_rst_ir",   out_ir, 0);
        chk("t4_rst_vld",  out_ir_valid, 0);
        chk("t4_rst_busy", out_busy, 0);
        chk("t4_rst_pc",   out_pc, 0);
        rst_n = 1'b1; ready_force = 1'b0;
        @(negedge clk);
        chk("t4_post_req", out_imem_req, 0);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
